p18_paddle_controller: RTL
==========================

Name: p18_paddle_controller

Overview:
Upstream of the paddle painter. Converts two raw player buttons into the paddle's left-edge x coordinate. Includes synchronisation, per-frame debounce, two-speed acceleration and screen-edge clamping. x changes only on the frame tick, so the painter never sees a mid-frame jump; x feeds the painter's x input directly.

Parameters:
SCREEN_WIDTH, 640, visible pixels per line
PADDLE_SEGMENT_WIDTH, 8, pixels per paddle segment
PADDLE_NUM_SEGMENTS, 6, segments per paddle; PADDLE_WIDTH = product = 48
DEBOUNCE_FRAMES, 2, consecutive frame ticks an input must disagree with the debounced state before it is accepted (>=1)
ACCEL_FRAMES, 8, number of slow moves before switching to fast (>=1)
SLOW_SPEED, 2, pixels per frame in slow state
FAST_SPEED, 6, pixels per frame in fast state

Ports:
clk  input  1  pixel clock
nRst  input  1  asynchronous active-low reset
btn_left  input  1  raw, asynchronous, active-high
btn_right  input  1  raw, asynchronous, active-high
frame_tick  input  1  one-cycle pulse, once per frame, during vertical blanking
center_req  input  1  one-cycle pulse; recentres the paddle (serve/new game)
x  output  10  paddle left edge, 0..X_MAX where X_MAX = SCREEN_WIDTH - PADDLE_WIDTH (592)
at_left  output  1  x == 0
at_right  output  1  x == X_MAX
moving  output  1  state != IDLE

Behaviour:
- Reset: nRst is asynchronous, active-low; clock is clk. Reset values: x = X_CENTER = X_MAX/2 (296), state IDLE, all counters 0, debounced buttons 0. Resulting outputs: at_left=0, at_right=0, moving=0.
- Sync: each button passes through a 2-flop synchroniser (reset 0). All logic below uses the synchronised value.
- Debounce, per button, evaluated only on frame_tick:
  - sync == db: cnt <= 0.
  - sync != db and cnt == DEBOUNCE_FRAMES-1: db <= sync, cnt <= 0.
  - otherwise: cnt++.
- Movement, evaluated on frame_tick, uses db values registered before this tick's debounce update. A press stable for N ticks therefore first moves x on tick N+1.
- Direction request: exactly one db button high gives LEFT or RIGHT. Neither or both gives none.
- FSM states IDLE, SLOW, FAST, plus a dir register and a hold_cnt register sized for ACCEL_FRAMES. Transitions on frame_tick:
  - Request none: state IDLE, hold_cnt 0, x unchanged.
  - IDLE with request: move SLOW_SPEED, state SLOW, hold_cnt 1, dir latched.
  - SLOW, same dir: move SLOW_SPEED, hold_cnt++. If hold_cnt was ACCEL_FRAMES-1, state becomes FAST.
  - FAST, same dir: move FAST_SPEED.
  - SLOW or FAST with opposite dir: treated as IDLE with request, i.e. SLOW, hold_cnt 1, move SLOW_SPEED in the new dir.
- Arithmetic is done in 11 bits, so there is no wrap.
  - Left: x <= (x < speed) ? 0 : x - speed.
  - Right: x <= (x + speed > X_MAX) ? X_MAX : x + speed.
  - Hitting a clamp does not change the state. at_left and at_right are registered alongside x, or decoded combinationally from x; either way they track x in the same cycle.
- center_req has priority over frame_tick in the same cycle: x <= X_CENTER, state IDLE, hold_cnt 0. Debounce counters are unaffected.
- x is constant between frame ticks. A change is visible the cycle after frame_tick or center_req.
- nRst asserted mid-frame forces all reset values immediately (asynchronous).

Decomposition:
- Shared package p18_pkg holds:
  - SCREEN_WIDTH, PADDLE_SEGMENT_WIDTH and PADDLE_NUM_SEGMENTS, also used by the painter;
  - derived PADDLE_WIDTH, X_MAX, X_CENTER;
  - the state encoding (IDLE=0, SLOW=1, FAST=2).
- One sub-module, p18_button_debounce: synchroniser plus per-frame debounce counter, instantiated twice. Ports: clk, nRst, raw, frame_tick, db.

Test Plan:
1. Reset, no buttons, 5 frame ticks -> x=296, moving=0, at_left=at_right=0 throughout.
2. Hold btn_right from reset, DEBOUNCE_FRAMES=2 -> x stays 296 through tick 2, then 298 after tick 3. After 8 slow moves x=312, then 318, 324 (FAST). moving=1 from tick 3.
3. Hold btn_left from x=4 in FAST -> x=0 next tick, at_left=1, stays 0 on further ticks. Same for right: x=590 +6 -> 592, at_right=1.
4. Both buttons held while in FAST at x=320 -> next tick state IDLE, x=320, moving=0. Release btn_left only -> resumes SLOW (+2) after debounce.
5. A 1-frame glitch on btn_left (high for a single tick), DEBOUNCE_FRAMES=2 -> x unchanged, state IDLE. center_req and frame_tick in the same cycle while moving -> x=296, IDLE.
6. Assert nRst mid-frame while x=500 in FAST -> x=296, moving=0 immediately. Debounce must re-qualify the held button before motion resumes.

Source files
------------

// File: rtl/p18_pkg.sv
// Shared paddle geometry and controller encodings.
// Used by the paddle controller and the paddle painter.
package p18_pkg;

  localparam int SCREEN_WIDTH         = 640;
  localparam int PADDLE_SEGMENT_WIDTH = 8;
  localparam int PADDLE_NUM_SEGMENTS  = 6;
  localparam int PADDLE_WIDTH =
    PADDLE_SEGMENT_WIDTH * PADDLE_NUM_SEGMENTS;
  localparam int X_MAX    = SCREEN_WIDTH - PADDLE_WIDTH;
  localparam int X_CENTER = X_MAX / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // One clamped step; 11-bit math so neither side wraps.
  function automatic logic [9:0] step_x(
    input logic [9:0]  x,
    input logic [10:0] spd,
    input logic        right
  );
    logic [10:0] xe;
    logic [10:0] sum;
    xe  = {1'b0, x};
    sum = xe + spd;
    if (right) begin
      if (sum > 11'(X_MAX)) return 10'(X_MAX);
      return sum[9:0];
    end
    if (xe < spd) return 10'd0;
    return 10'(xe - spd);
  endfunction

endpackage

// File: rtl/p18_paddle_controller_if.sv
// Paddle controller button/control inputs and position outputs.
// master drives buttons, frame_tick, center_req; slave returns x and flags.
interface p18_paddle_controller_if;

  logic       btn_left;
  logic       btn_right;
  logic       frame_tick;
  logic       center_req;
  logic [9:0] x;
  logic       at_left;
  logic       at_right;
  logic       moving;

  modport master (
    output btn_left, btn_right, frame_tick, center_req,
    input  x, at_left, at_right, moving
  );

  modport slave (
    input  btn_left, btn_right, frame_tick, center_req,
    output x, at_left, at_right, moving
  );

endinterface

// File: rtl/p18_button_debounce.sv
// 2-flop synchroniser plus per-frame debounce for one raw button.
// Ports: clk, nRst, raw (async), frame_tick, db (debounced level).
module p18_button_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic nRst,
  input  logic raw,
  input  logic frame_tick,
  output logic db
);

  localparam int CW =
    (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (frame_tick) begin
      if (sync_q[1] == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        db_d  = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/p18_paddle_controller.sv
// Buttons -> paddle left-edge x, updated once per frame.
// Ports: clk, nRst, bus (slave: buttons/tick/center in, x/flags out).
module p18_paddle_controller
  import p18_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int ACCEL_FRAMES    = 8,
  parameter int SLOW_SPEED      = 2,
  parameter int FAST_SPEED      = 6
) (
  input logic                    clk,
  input logic                    nRst,
  p18_paddle_controller_if.slave bus
);

  localparam int HW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_FRAMES - 1);

  logic db_left, db_right;

  p18_button_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_db_left (
    .clk       (clk),
    .nRst      (nRst),
    .raw       (bus.btn_left),
    .frame_tick(bus.frame_tick),
    .db        (db_left)
  );

  p18_button_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_db_right (
    .clk       (clk),
    .nRst      (nRst),
    .raw       (bus.btn_right),
    .frame_tick(bus.frame_tick),
    .db        (db_right)
  );

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    x_q, x_d;
  logic          at_left_q, at_right_q, moving_q;

  logic          req_valid;
  dir_e          req_dir;
  logic          move;
  logic [10:0]   spd;

  // db_left/db_right are the pre-update values on a tick.
  assign req_valid = db_left ^ db_right;
  assign req_dir   = db_right ? DIR_RIGHT : DIR_LEFT;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    x_d     = x_q;
    move    = 1'b0;
    spd     = 11'(SLOW_SPEED);
    if (bus.center_req) begin
      x_d     = 10'(X_CENTER);
      state_d = ST_IDLE;
      hold_d  = '0;
    end else if (bus.frame_tick) begin
      if (!req_valid) begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end else if (state_q == ST_IDLE || dir_q != req_dir) begin
        state_d = ST_SLOW;
        hold_d  = HW'(1);
        dir_d   = req_dir;
        move    = 1'b1;
      end else if (state_q == ST_SLOW) begin
        move   = 1'b1;
        hold_d = hold_q + HW'(1);
        if (hold_q >= HOLD_LAST) state_d = ST_FAST;
      end else begin
        move = 1'b1;
        spd  = 11'(FAST_SPEED);
      end
      if (move) x_d = step_x(x_q, spd, dir_d == DIR_RIGHT);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_LEFT;
      hold_q     <= '0;
      x_q        <= 10'(X_CENTER);
      at_left_q  <= 1'b0;
      at_right_q <= 1'b0;
      moving_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hold_q     <= hold_d;
      x_q        <= x_d;
      at_left_q  <= (x_d == 10'd0);
      at_right_q <= (x_d == 10'(X_MAX));
      moving_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.x        = x_q;
  assign bus.at_left  = at_left_q;
  assign bus.at_right = at_right_q;
  assign bus.moving   = moving_q;

endmodule
